merge: RTL and testbench

- Write-back counterpart of the input-side split buffer.
- Accepts one KERNEL_LENGTH-word result vector per cycle from the compute array and buffers it.
- Serialises the buffer into single DATA_WIDTH words, in bursts of BURST_LENGTH, for the DMA write channel.
- Sits between the PE/accumulator outputs and the DMA write master.

---
 rtl/accel_pkg.sv | 11 +
 rtl/merge_beat_cnt.sv | 27 ++
 rtl/merge.sv | 90 +++++++++
 tb/tb_merge.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared word/vector definitions for the split and merge buffers around the compute array.
package accel_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int BURST_LENGTH  = 32;
  localparam int KERNEL_LENGTH = 3;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef word_t [KERNEL_LENGTH-1:0] vec_t;

endpackage

// File: rtl/merge_beat_cnt.sv
// Burst beat counter for the merge buffer: counts accepted pops and flags the final beat of a burst.
module merge_beat_cnt
  import accel_pkg::*;
#(
  parameter int BURST = BURST_LENGTH
) (
  input  logic clk,
  input  logic rst,
  input  logic pop,
  output logic at_last
);

  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

  logic [BW-1:0] beat;

  assign at_last = (beat == BW'(BURST - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat <= '0;
    end else if (pop) begin
      beat <= at_last ? '0 : beat + 1'b1;
    end
  end

endmodule

// File: rtl/merge.sv
// Write-back merge buffer: takes one KERNEL_LENGTH-word vector per push and serialises it
// word by word (lane 0 first) toward the DMA write channel, marking burst boundaries.
module merge
  import accel_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  wen,
  input  vec_t  din,
  input  logic  ren,
  output word_t dout,
  output logic  valid,
  output logic  last,
  output logic  burst_ready,
  output logic  full_flag,
  output logic  empty_flag,
  output logic  overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshake: a push (wen) is taken only while !full_flag and a pop (ren) only while
  // !empty_flag, both judged on the count before the edge. An accepted pop presents its
  // word on dout with valid=1 exactly one cycle later; last rides with that valid.
  word_t         mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          at_last;

  assign full_flag   = (CW'(DEPTH) - count) < CW'(KERNEL_LENGTH);
  assign empty_flag  = (count == '0);
  assign burst_ready = (count >= CW'(BURST_LENGTH));

  assign push = wen && !full_flag;
  assign pop  = ren && !empty_flag;

  // Storage has no reset; pointer wrap lets a vector straddle the top of the ring.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < KERNEL_LENGTH; i++) begin
        mem[wptr + AW'(i)] <= din[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      dout     <= '0;
      valid    <= 1'b0;
      last     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(KERNEL_LENGTH);
      end
      if (wen && full_flag) begin
        overflow <= 1'b1;
      end
      count <= count + (push ? CW'(KERNEL_LENGTH) : CW'(0)) - CW'(pop);
      if (pop) begin
        dout  <= mem[rptr];
        rptr  <= rptr + 1'b1;
        valid <= 1'b1;
        last  <= at_last;
      end else begin
        valid <= 1'b0;
        last  <= 1'b0;
      end
    end
  end

  merge_beat_cnt #(
    .BURST(BURST_LENGTH)
  ) u_beat_cnt (
    .clk    (clk),
    .rst    (rst),
    .pop    (pop),
    .at_last(at_last)
  );

endmodule

// File: tb/tb_merge.sv
// Testbench for merge: directed push/pop sequences, a word scoreboard drained by a monitor.
module tb_merge;
  import accel_pkg::*;

  localparam int DEPTH = 64;
  localparam int K     = KERNEL_LENGTH;

  logic  clk;
  logic  rst;
  logic  wen;
  vec_t  din;
  logic  ren;
  word_t dout;
  logic  valid;
  logic  last;
  logic  burst_ready;
  logic  full_flag;
  logic  empty_flag;
  logic  overflow;

  merge #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .wen        (wen),
    .din        (din),
    .ren        (ren),
    .dout       (dout),
    .valid      (valid),
    .last       (last),
    .burst_ready(burst_ready),
    .full_flag  (full_flag),
    .empty_flag (empty_flag),
    .overflow   (overflow)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state and bench model
  logic [DATA_WIDTH-1:0] exp_q[$];
  int m_count;
  bit exp_ovf;
  int mon_beat;
  int n_checks;
  int n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_flags();
    chk("full_flag",   64'(full_flag),   64'((DEPTH - m_count) < K));
    chk("empty_flag",  64'(empty_flag),  64'(m_count == 0));
    chk("burst_ready", 64'(burst_ready), 64'(m_count >= BURST_LENGTH));
    chk("overflow",    64'(overflow),    64'(exp_ovf));
  endtask

  // Driver: one cycle of stimulus, model judged on pre-edge count
  task automatic step(input logic w, input vec_t d, input logic r);
    bit ap;
    bit pp;
    ap  = w && ((DEPTH - m_count) >= K);
    pp  = r && (m_count > 0);
    wen = w;
    din = d;
    ren = r;
    if (ap) for (int i = 0; i < K; i++) exp_q.push_back(d[i]);
    if (w && !ap) exp_ovf = 1'b1;
    m_count = m_count + (ap ? K : 0) - (pp ? 1 : 0);
    @(posedge clk);
    #1;
    wen = 1'b0;
    ren = 1'b0;
    check_flags();
  endtask

  function automatic vec_t mk_vec(input int tag);
    vec_t v;
    for (int i = 0; i < K; i++) v[i] = DATA_WIDTH'(tag * 16 + i);
    return v;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (m_count > 0 && guard < 4 * DEPTH) begin
      step(1'b0, '0, 1'b1);
      guard++;
    end
    idle(2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wen = 1'b0;
    ren = 1'b0;
    exp_q.delete();
    m_count = 0;
    exp_ovf = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_dout",  64'(dout), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_last",  64'(last), 64'd0);
    check_flags();
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a word
  initial begin
    mon_beat = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_beat = 0;
      end else if (valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 64'(dout), 64'hdead);
        end else begin
          chk("dout", 64'(dout), 64'(exp_q.pop_front()));
          chk("last", 64'(last), 64'(mon_beat == BURST_LENGTH - 1));
          mon_beat = (mon_beat + 1) % BURST_LENGTH;
        end
      end else begin
        chk("last_without_valid", 64'(last), 64'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    vec_t v;
    int   seq;
    n_checks = 0;
    n_fail   = 0;
    m_count  = 0;
    exp_ovf  = 1'b0;
    rst = 1'b1;
    wen = 1'b0;
    ren = 1'b0;
    din = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Lane order: lane 0 first, one cycle after each ren
    step(1'b1, {32'd3, 32'd2, 32'd1}, 1'b0);
    step(1'b0, '0, 1'b1);
    chk("lane0_valid", 64'(valid), 64'd1);
    chk("lane0_dout",  64'(dout), 64'd1);
    step(1'b0, '0, 1'b1);
    chk("lane1_dout",  64'(dout), 64'd2);
    step(1'b0, '0, 1'b1);
    chk("lane2_dout",  64'(dout), 64'd3);
    step(1'b0, '0, 1'b0);
    chk("valid_drop",  64'(valid), 64'd0);
    idle(1);

    // Reset mid-stream with data buffered and a pop in flight
    step(1'b1, mk_vec(1), 1'b0);
    step(1'b1, mk_vec(2), 1'b1);
    do_reset();

    // Fill to full, then an overflowing push that must be dropped
    for (int n = 0; n < 20; n++) step(1'b1, mk_vec(100 + n), 1'b0);
    chk("full_at_60", 64'(full_flag), 64'd0);
    step(1'b1, mk_vec(120), 1'b0);
    chk("full_at_63", 64'(full_flag), 64'd1);
    step(1'b1, mk_vec(121), 1'b0);
    chk("overflow_set", 64'(overflow), 64'd1);
    drain();
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // Burst boundary: last only on the 32nd word
    do_reset();
    for (int n = 0; n < 11; n++) step(1'b1, mk_vec(200 + n), 1'b0);
    chk("burst_ready_33", 64'(burst_ready), 64'd1);
    for (int n = 0; n < BURST_LENGTH; n++) step(1'b0, '0, 1'b1);
    chk("last_32nd", 64'(last), 64'd1);
    step(1'b0, '0, 1'b0);
    chk("burst_ready_1", 64'(burst_ready), 64'd0);
    chk("empty_1", 64'(empty_flag), 64'd0);
    drain();

    // Simultaneous push and pop at count 5
    step(1'b1, mk_vec(300), 1'b0);
    step(1'b1, mk_vec(301), 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b1, mk_vec(302), 1'b1);
    chk("simul_oldest", 64'(dout), 64'(mk_vec(300) >> DATA_WIDTH) & 64'hffff_ffff);
    for (int n = 0; n < 7; n++) begin
      chk("simul_not_empty", 64'(empty_flag), 64'd0);
      step(1'b0, '0, 1'b1);
    end
    chk("simul_empty_after_7", 64'(empty_flag), 64'd1);
    idle(2);

    // Wrap-around: more than 3*DEPTH words through the ring with mixed traffic
    seq = 0;
    for (int i = 0; i < 330; i++) begin
      for (int l = 0; l < K; l++) begin
        v[l] = {16'($urandom_range(0, 65535)), 16'(seq)};
        seq++;
      end
      step(1'b1 && (i % 3 == 0), v, (i % 7) != 3);
    end
    drain();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
